// File: rtl/cu1.sv
// cu1: EC-2 control unit sequencing START/FETCH/DECODE/EXECUTE and driving datapath controls.
module cu1 (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clock)
        state_q <= reset ? S_START : state_d;

    always_comb begin
        state_d = S_START;
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = 2'b00;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_DECODE;
                IRload  = 1'b1;
                PCload  = 1'b1;
            end
            // execute states are 8 + opcode
            S_DECODE: begin
                state_d = state_t'({1'b1, IR75});
                Meminst = 1'b1;
            end
            S_LOAD: begin
                state_d = S_FETCH;
                Meminst = 1'b1;
                Asel    = 2'b10;
                Aload   = 1'b1;
            end
            S_STORE: begin
                state_d = S_FETCH;
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            S_ADD: begin
                state_d = S_FETCH;
                Meminst = 1'b1;
                Aload   = 1'b1;
            end
            S_SUB: begin
                state_d = S_FETCH;
                Meminst = 1'b1;
                Sub     = 1'b1;
                Aload   = 1'b1;
            end
            S_INPUT: begin
                state_d = Enter ? S_FETCH : S_INPUT;
                Asel    = 2'b01;
                Aload   = Enter;
            end
            S_JZ: begin
                state_d = S_FETCH;
                JMPmux  = 1'b1;
                PCload  = Aeq0;
            end
            S_JPOS: begin
                state_d = S_FETCH;
                JMPmux  = 1'b1;
                PCload  = Apos;
            end
            S_HALT: begin
                state_d = S_HALT;
                Halt    = 1'b1;
            end
            default: state_d = S_START;
        endcase
    end

    assign state = state_q;
endmodule

// File: tb/tb_cu1.sv
// tb_cu1: table-driven and randomized checks of cu1 against an instruction-phase reference model.
module tb_cu1;
    logic       clock, reset, Aeq0, Apos, Enter;
    logic [2:0] IR75;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] state;
    logic [9:0] outs;

    cu1 dut (
        .clock(clock), .reset(reset), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr),
        .Asel(Asel), .Aload(Aload), .Sub(Sub), .Halt(Halt), .state(state)
    );

    assign outs = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,Halt}
    localparam logic [9:0] O_NONE  = 10'b0000000000;
    localparam logic [9:0] O_FETCH = 10'b1010000000;
    localparam logic [9:0] O_DEC   = 10'b0001000000;
    localparam logic [9:0] O_LOAD  = 10'b0001010100;
    localparam logic [9:0] O_STORE = 10'b0001100000;
    localparam logic [9:0] O_ADD   = 10'b0001000100;
    localparam logic [9:0] O_SUB   = 10'b0001000110;
    localparam logic [9:0] O_IN0   = 10'b0000001000;
    localparam logic [9:0] O_IN1   = 10'b0000001100;
    localparam logic [9:0] O_JT    = 10'b0110000000;
    localparam logic [9:0] O_JN    = 10'b0100000000;
    localparam logic [9:0] O_HALT  = 10'b0000000001;

    typedef struct {
        logic       rst;
        logic [2:0] ir;
        logic       aeq0, apos, enter;
        logic [3:0] st;
        logic [9:0] out;
    } vec_t;

    vec_t vec[$];
    int pass_cnt = 0;
    int total = 0;

    function automatic void add(logic rst, logic [2:0] ir, logic aeq0, logic apos, logic enter,
                                logic [3:0] st, logic [9:0] out);
        vec_t v;
        v.rst = rst; v.ir = ir; v.aeq0 = aeq0; v.apos = apos; v.enter = enter;
        v.st = st; v.out = out;
        vec.push_back(v);
    endfunction

    task automatic chk(string name, logic [9:0] got, logic [9:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    endtask

    task automatic drive(logic rst, logic [2:0] ir, logic aeq0, logic apos, logic enter);
        @(negedge clock);
        reset = rst; IR75 = ir; Aeq0 = aeq0; Apos = apos; Enter = enter;
        #1;
    endtask

    // Reference model: instruction phase (0 start, 1 fetch, 2 decode, 3 execute) plus latched opcode
    int ph, op;

    function automatic logic [9:0] model_out(int p, int o, logic z, logic pos, logic en);
        logic ex, irl, jmp, pcl, mem, wr, ald, sb, hlt;
        logic [1:0] as;
        ex  = (p == 3);
        irl = (p == 1);
        jmp = ex && (o == 5 || o == 6);
        pcl = (p == 1) || (ex && ((o == 5 && z) || (o == 6 && pos)));
        mem = (p == 2) || (ex && o < 4);
        wr  = ex && o == 1;
        as  = (ex && o == 0) ? 2'd2 : (ex && o == 4) ? 2'd1 : 2'd0;
        ald = ex && (o == 0 || o == 2 || o == 3 || (o == 4 && en));
        sb  = ex && o == 3;
        hlt = ex && o == 7;
        return {irl, jmp, pcl, mem, wr, as, ald, sb, hlt};
    endfunction

    function automatic logic [3:0] model_state(int p, int o);
        return (p == 3) ? 4'(8 + o) : 4'(p);
    endfunction

    initial begin
        reset = 1'b1; IR75 = 3'd0; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
        repeat (2) @(posedge clock);

        add(0,0,0,0,0, 0,  O_NONE);
        add(0,0,0,0,0, 1,  O_FETCH);
        add(0,0,0,0,0, 2,  O_DEC);
        add(0,0,0,0,0, 8,  O_LOAD);
        add(0,1,0,0,0, 1,  O_FETCH);
        add(0,1,0,0,0, 2,  O_DEC);
        add(0,2,0,0,0, 9,  O_STORE);
        add(0,2,0,0,0, 1,  O_FETCH);
        add(0,2,0,0,0, 2,  O_DEC);
        add(0,3,0,0,0, 10, O_ADD);
        add(0,3,0,0,0, 1,  O_FETCH);
        add(0,3,0,0,0, 2,  O_DEC);
        add(0,4,0,0,0, 11, O_SUB);
        add(0,4,0,0,0, 1,  O_FETCH);
        add(0,4,0,0,0, 2,  O_DEC);
        for (int i = 0; i < 4; i++) add(0,3'(i),1,1,0, 12, O_IN0);
        add(0,0,0,0,1, 12, O_IN1);
        add(0,5,1,0,1, 1,  O_FETCH);
        add(0,5,1,0,1, 2,  O_DEC);
        add(0,5,1,0,1, 13, O_JT);
        add(0,5,0,1,0, 1,  O_FETCH);
        add(0,5,0,1,0, 2,  O_DEC);
        add(0,5,0,1,0, 13, O_JN);
        add(0,6,0,1,0, 1,  O_FETCH);
        add(0,6,0,1,0, 2,  O_DEC);
        add(0,6,0,1,0, 14, O_JT);
        add(0,6,1,0,0, 1,  O_FETCH);
        add(0,6,1,0,0, 2,  O_DEC);
        add(0,6,1,0,0, 14, O_JN);
        add(0,7,0,0,0, 1,  O_FETCH);
        add(0,7,0,0,0, 2,  O_DEC);
        for (int i = 0; i < 11; i++) add(0,3'(i),i[0],i[1],i[2], 15, O_HALT);
        add(1,0,1,1,1, 15, O_HALT);
        add(0,0,0,0,0, 0,  O_NONE);
        add(0,0,0,0,0, 1,  O_FETCH);
        add(1,0,0,0,1, 2,  O_DEC);
        add(0,0,0,0,1, 0,  O_NONE);
        add(0,4,0,0,0, 1,  O_FETCH);
        add(0,4,0,0,0, 2,  O_DEC);
        add(0,4,0,0,0, 12, O_IN0);
        add(1,4,0,0,0, 12, O_IN0);
        add(0,0,0,0,1, 0,  O_NONE);
        add(0,0,0,0,1, 1,  O_FETCH);

        foreach (vec[i]) begin
            drive(vec[i].rst, vec[i].ir, vec[i].aeq0, vec[i].apos, vec[i].enter);
            chk($sformatf("vec%0d_state", i), 10'(state), 10'(vec[i].st));
            chk($sformatf("vec%0d_outs", i), outs, vec[i].out);
        end

        // JZ flag toggling within the execute cycle resolves combinationally
        drive(1,0,0,0,0);
        drive(0,5,0,0,0);
        drive(0,5,0,0,0);
        drive(0,5,0,0,0);
        drive(0,5,0,0,0);
        chk("jz_state", 10'(state), 10'd13);
        chk("jz_pc_flag0", 10'(PCload), 10'd0);
        Aeq0 = 1'b1;
        #1;
        chk("jz_pc_flag1", 10'(PCload), 10'd1);
        drive(0,0,0,0,0);
        chk("jz_to_fetch", 10'(state), 10'd1);

        // randomized run against the phase model
        drive(1,0,0,0,0);
        @(posedge clock);
        ph = 0; op = 0;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 59) == 0), 3'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0));
            chk("rnd_state", 10'(state), 10'(model_state(ph, op)));
            chk("rnd_outs", outs, model_out(ph, op, Aeq0, Apos, Enter));
            if (reset) ph = 0;
            else if (ph == 0) ph = 1;
            else if (ph == 1) ph = 2;
            else if (ph == 2) begin ph = 3; op = int'(IR75); end
            else if (op == 7 || (op == 4 && !Enter)) ph = 3;
            else ph = 1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
